// File: rtl/sa_cache_pkg.sv
// Shared types and helpers for the set-associative write-back cache:
// controller states, address-field widths and tree-PLRU arithmetic.
package sa_cache_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      WRITEBACK,
      REFILL_REQ,
      REFILL_WAIT,
      RESPOND
   } state_e;

   // Wide enough for the PLRU tree of a 64-way cache; narrower trees are zero-extended.
   localparam int unsigned PLRU_MAX = 63;
   typedef logic [PLRU_MAX-1:0] plru_t;

   function automatic int unsigned off_w(int unsigned line_bytes);
      return $clog2(line_bytes);
   endfunction

   function automatic int unsigned idx_w(int unsigned sets);
      return $clog2(sets);
   endfunction

   function automatic int unsigned tag_w(int unsigned addr_w, int unsigned sets,
                                         int unsigned line_bytes);
      return addr_w - idx_w(sets) - off_w(line_bytes);
   endfunction

   // Heap-ordered tree: node n has children 2n+1 / 2n+2; a bit of 1 points right.
   function automatic plru_t plru_update(plru_t bits, int unsigned way, int unsigned ways);
      plru_t       r    = bits;
      int unsigned node = 0;
      int unsigned lvls = $clog2(ways);
      int unsigned dir;
      for (int unsigned l = 0; l < 6; l++) begin
         if (l < lvls) begin
            dir     = (way >> (lvls - 1 - l)) & 1;
            r[node] = (dir == 0);
            node    = 2 * node + 1 + dir;
         end
      end
      return r;
   endfunction

   function automatic int unsigned plru_victim(plru_t bits, int unsigned ways);
      int unsigned node = 0;
      int unsigned lvls = $clog2(ways);
      for (int unsigned l = 0; l < 6; l++) begin
         if (l < lvls) node = 2 * node + (bits[node] ? 2 : 1);
      end
      return node - (ways - 1);
   endfunction

endpackage

// File: rtl/sa_cache_wb_plru_tree.sv
// Per-set tree-PLRU state: one update port and a combinational victim pointer
// for the set currently being looked up.
module plru_tree
   import sa_cache_pkg::*;
#(
   parameter int unsigned WAYS = 4,
   parameter int unsigned SETS = 256
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     upd_en_i,
   input  logic [$clog2(SETS)-1:0]  set_i,
   input  logic [$clog2(WAYS)-1:0]  upd_way_i,
   output logic [$clog2(WAYS)-1:0]  victim_o
);

   localparam int unsigned NB = WAYS - 1;
   localparam int unsigned WW = $clog2(WAYS);

   logic [NB-1:0] bits_q [SETS];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < SETS; s++) bits_q[s] <= '0;
      end else if (upd_en_i) begin
         bits_q[set_i] <= NB'(plru_update(plru_t'(bits_q[set_i]), 32'(upd_way_i), WAYS));
      end
   end

   assign victim_o = WW'(plru_victim(plru_t'(bits_q[set_i]), WAYS));

endmodule

// File: rtl/sa_cache_wb.sv
// N-way set-associative write-back, write-allocate data cache with tree-PLRU
// replacement and a blocking single-request controller.
module sa_cache_wb
   import sa_cache_pkg::*;
#(
   parameter int unsigned WAYS       = 4,
   parameter int unsigned SETS       = 256,
   parameter int unsigned LINE_BYTES = 64,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cpu_valid,
   output logic                      cpu_ready,
   input  logic                      cpu_we,
   input  logic [ADDR_WIDTH-1:0]     cpu_addr,
   input  logic [DATA_WIDTH-1:0]     cpu_wdata,
   input  logic [DATA_WIDTH/8-1:0]   cpu_be,
   output logic                      cpu_resp_valid,
   output logic [DATA_WIDTH-1:0]     cpu_rdata,
   output logic                      mem_req_valid,
   input  logic                      mem_req_ready,
   output logic                      mem_req_we,
   output logic [ADDR_WIDTH-1:0]     mem_req_addr,
   output logic [LINE_BYTES*8-1:0]   mem_req_wdata,
   input  logic                      mem_resp_valid,
   input  logic [LINE_BYTES*8-1:0]   mem_resp_line
);

   localparam int unsigned BE_W   = DATA_WIDTH / 8;
   localparam int unsigned LINE_W = LINE_BYTES * 8;
   localparam int unsigned OFF_W  = off_w(LINE_BYTES);
   localparam int unsigned IDX_W  = idx_w(SETS);
   localparam int unsigned TAG_W  = tag_w(ADDR_WIDTH, SETS, LINE_BYTES);
   localparam int unsigned WW     = $clog2(WAYS);
   localparam int unsigned BSEL_W = $clog2(BE_W);

   typedef logic [LINE_W-1:0] line_t;

   state_e                state_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  we_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [BE_W-1:0]       be_q;
   logic [WW-1:0]         victim_q;
   logic                  mem_req_valid_q, mem_req_we_q;
   logic [ADDR_WIDTH-1:0] mem_req_addr_q;
   line_t                 mem_req_wdata_q;

   logic [TAG_W-1:0] tag_q   [WAYS][SETS];
   line_t            data_q  [WAYS][SETS];
   logic [WAYS-1:0]  valid_q [SETS];
   logic [WAYS-1:0]  dirty_q [SETS];

   logic [TAG_W-1:0] req_tag;
   logic [IDX_W-1:0] req_idx;
   logic [OFF_W-1:0] req_wsel;
   assign req_tag  = addr_q[ADDR_WIDTH-1 -: TAG_W];
   assign req_idx  = addr_q[OFF_W +: IDX_W];
   assign req_wsel = addr_q[OFF_W-1:0] >> BSEL_W;

   function automatic line_t merge_word(line_t line, logic [OFF_W-1:0] wsel,
                                        logic [DATA_WIDTH-1:0] d, logic [BE_W-1:0] be);
      line_t r = line;
      for (int b = 0; b < BE_W; b++)
         if (be[b]) r[int'(wsel) * DATA_WIDTH + b * 8 +: 8] = d[b * 8 +: 8];
      return r;
   endfunction

   logic          hit, inv_found, refill_fire, store_hit, wr_en;
   logic [WW-1:0] hit_way, inv_way, plru_way, victim_sel, wr_way;
   line_t         hit_line, wr_base, wr_line, rd_line;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      hit       = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[req_idx][w] && tag_q[w][req_idx] == req_tag) begin
            hit     = 1'b1;
            hit_way = WW'(w);
         end
         if (!valid_q[req_idx][w] && !inv_found) begin
            inv_found = 1'b1;
            inv_way   = WW'(w);
         end
      end
   end

   assign victim_sel  = inv_found ? inv_way : plru_way;
   assign hit_line    = data_q[hit_way][req_idx];
   assign refill_fire = (state_q == REFILL_WAIT) && mem_resp_valid;
   assign store_hit   = (state_q == LOOKUP) && hit && we_q;
   assign wr_en       = refill_fire || store_hit;
   assign wr_way      = refill_fire ? victim_q : hit_way;
   assign wr_base     = refill_fire ? mem_resp_line : hit_line;
   assign wr_line     = we_q ? merge_word(wr_base, req_wsel, wdata_q, be_q) : wr_base;

   plru_tree #(.WAYS(WAYS), .SETS(SETS)) u_plru (
      .clk       (clk),
      .rst       (rst),
      .upd_en_i  (((state_q == LOOKUP) && hit) || refill_fire),
      .set_i     (req_idx),
      .upd_way_i (wr_way),
      .victim_o  (plru_way)
   );

   // NOTE: tag/data storage has no reset; valid bits gate every use, and resetting it would cost a mux per bit.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         data_q[wr_way][req_idx] <= wr_line;
         tag_q[wr_way][req_idx]  <= req_tag;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= IDLE;
         addr_q          <= '0;
         we_q            <= 1'b0;
         wdata_q         <= '0;
         be_q            <= '0;
         victim_q        <= '0;
         mem_req_valid_q <= 1'b0;
         mem_req_we_q    <= 1'b0;
         mem_req_addr_q  <= '0;
         mem_req_wdata_q <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
         end
      end else begin
         case (state_q)
            IDLE: if (cpu_valid) begin
               addr_q  <= cpu_addr;
               we_q    <= cpu_we;
               wdata_q <= cpu_wdata;
               be_q    <= cpu_be;
               state_q <= LOOKUP;
            end
            LOOKUP: begin
               if (hit) begin
                  if (we_q) dirty_q[req_idx][hit_way] <= 1'b1;
                  state_q <= IDLE;
               end else begin
                  victim_q        <= victim_sel;
                  mem_req_valid_q <= 1'b1;
                  if (valid_q[req_idx][victim_sel] && dirty_q[req_idx][victim_sel]) begin
                     mem_req_we_q    <= 1'b1;
                     mem_req_addr_q  <= {tag_q[victim_sel][req_idx], req_idx, OFF_W'(0)};
                     mem_req_wdata_q <= data_q[victim_sel][req_idx];
                     state_q         <= WRITEBACK;
                  end else begin
                     mem_req_we_q   <= 1'b0;
                     mem_req_addr_q <= {req_tag, req_idx, OFF_W'(0)};
                     state_q        <= REFILL_REQ;
                  end
               end
            end
            WRITEBACK: if (mem_req_ready) begin
               mem_req_we_q    <= 1'b0;
               mem_req_addr_q  <= {req_tag, req_idx, OFF_W'(0)};
               mem_req_wdata_q <= '0;
               state_q         <= REFILL_REQ;
            end
            REFILL_REQ: if (mem_req_ready) begin
               mem_req_valid_q <= 1'b0;
               mem_req_addr_q  <= '0;
               state_q         <= REFILL_WAIT;
            end
            REFILL_WAIT: if (mem_resp_valid) begin
               valid_q[req_idx][victim_q] <= 1'b1;
               dirty_q[req_idx][victim_q] <= we_q;
               state_q                    <= RESPOND;
            end
            RESPOND: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Hits answer in the lookup cycle itself, so the response path decodes state directly.
   assign rd_line        = (state_q == RESPOND) ? data_q[victim_q][req_idx] : hit_line;
   assign cpu_ready      = (state_q == IDLE);
   assign cpu_resp_valid = ((state_q == LOOKUP) && hit) || (state_q == RESPOND);
   assign cpu_rdata      = (cpu_resp_valid && !we_q) ?
                           rd_line[int'(req_wsel) * DATA_WIDTH +: DATA_WIDTH] : '0;
   assign mem_req_valid  = mem_req_valid_q;
   assign mem_req_we     = mem_req_we_q;
   assign mem_req_addr   = mem_req_addr_q;
   assign mem_req_wdata  = mem_req_wdata_q;

endmodule

// File: tb/tb_sa_cache_wb.sv
// Directed bench for sa_cache_wb: a vector table of loads/stores with
// hand-computed data and latency, plus stall and mid-refill reset sequences.
module tb_sa_cache_wb;

   logic         clk, rst;
   logic         cpu_valid, cpu_ready, cpu_we, cpu_resp_valid;
   logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
   logic [3:0]   cpu_be;
   logic         mem_req_valid, mem_req_ready, mem_req_we, mem_resp_valid;
   logic [31:0]  mem_req_addr;
   logic [511:0] mem_req_wdata, mem_resp_line;

   sa_cache_wb #(.WAYS(4), .SETS(256), .LINE_BYTES(64), .DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_resp_valid(cpu_resp_valid), .cpu_rdata(cpu_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
      .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
      .mem_resp_valid(mem_resp_valid), .mem_resp_line(mem_resp_line)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp_rdata;
      int          exp_lat;
      int          exp_rd;
      int          exp_wb;
   } vec_t;

   vec_t         vecs [22];
   int           n_vec = 0, n_err = 0;
   int           rd_cnt = 0, wb_cnt = 0;
   logic [31:0]  wb_addr = '0, rd_addr = '0;
   logic [511:0] wb_line = '0;
   bit           resp_hold = 1'b0, pend = 1'b0;
   logic [511:0] backing [logic [31:0]];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Memory contents: written-back lines are remembered; line 0x1000 is special, others hold their own addresses.
   function automatic logic [511:0] line_of(logic [31:0] a);
      logic [511:0] l;
      if (backing.exists(a)) return backing[a];
      for (int i = 0; i < 16; i++)
         l[i*32 +: 32] = (a == 32'h1000) ? ((i == 0) ? 32'hDEADBEEF : 32'hAAAAAAAA) : a + 32'(i * 4);
      return l;
   endfunction

   // Memory responder: handshakes are judged 1 time unit before each rising edge.
   initial begin
      mem_resp_valid = 1'b0;
      mem_resp_line  = '0;
      forever begin
         @(negedge clk);
         mem_resp_valid = 1'b0;
         if (pend && !resp_hold) begin
            mem_resp_valid = 1'b1;
            mem_resp_line  = line_of(rd_addr);
            pend           = 1'b0;
         end
         #4;
         if (!rst) pend = 1'b0;
         else if (mem_req_valid && mem_req_ready) begin
            if (mem_req_we) begin
               wb_cnt++;
               wb_addr = mem_req_addr;
               wb_line = mem_req_wdata;
               backing[mem_req_addr] = mem_req_wdata;
            end else begin
               rd_cnt++;
               rd_addr = mem_req_addr;
               pend    = 1'b1;
            end
         end
      end
   end

   task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      int n = 0;
      @(negedge clk);
      while (!cpu_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!cpu_ready) check("cpu_ready timeout", {63'd0, cpu_ready}, 64'd1);
      cpu_valid = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_be = be;
      @(posedge clk);
   endtask

   task automatic wait_resp(output logic [31:0] rdata, output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         cpu_valid = 1'b0;
         lat++;
      end while (!cpu_resp_valid && lat < 200);
      rdata = cpu_rdata;
   endtask

   task automatic run_vecs(input int lo, input int hi);
      logic [31:0] rdata;
      int          lat, rd0, wb0;
      for (int i = lo; i <= hi; i++) begin
         rd0 = rd_cnt;
         wb0 = wb_cnt;
         issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be);
         wait_resp(rdata, lat);
         check($sformatf("v%0d rdata", i), {32'd0, rdata}, {32'd0, vecs[i].exp_rdata});
         check($sformatf("v%0d latency", i), 64'(lat), 64'(vecs[i].exp_lat));
         check($sformatf("v%0d refills", i), 64'(rd_cnt - rd0), 64'(vecs[i].exp_rd));
         check($sformatf("v%0d writebacks", i), 64'(wb_cnt - wb0), 64'(vecs[i].exp_wb));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] rdata;
      int          lat, rd0, n;
      bit          stable, rdy_seen, resp_seen;

      rst = 1'b0; cpu_valid = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
      mem_req_ready = 1'b1;

      //          we    addr           wdata          be     rdata          lat rd wb
      vecs[0]  = '{1'b0, 32'h0000_1000, 32'h0,         4'h0, 32'hDEADBEEF, 4, 1, 0};
      vecs[1]  = '{1'b0, 32'h0000_1000, 32'h0,         4'h0, 32'hDEADBEEF, 1, 0, 0};
      vecs[2]  = '{1'b0, 32'h0000_1004, 32'h0,         4'h0, 32'hAAAAAAAA, 1, 0, 0};
      vecs[3]  = '{1'b1, 32'h0000_1004, 32'h12345678,  4'h3, 32'h0,        1, 0, 0};
      vecs[4]  = '{1'b0, 32'h0000_1004, 32'h0,         4'h0, 32'hAAAA5678, 1, 0, 0};
      vecs[5]  = '{1'b0, 32'h0000_5000, 32'h0,         4'h0, 32'h00005000, 4, 1, 0};
      vecs[6]  = '{1'b0, 32'h0000_9004, 32'h0,         4'h0, 32'h00009004, 4, 1, 0};
      vecs[7]  = '{1'b0, 32'h0000_D03C, 32'h0,         4'h0, 32'h0000D03C, 4, 1, 0};
      vecs[8]  = '{1'b0, 32'h0001_1000, 32'h0,         4'h0, 32'h00011000, 5, 1, 1};
      vecs[9]  = '{1'b1, 32'h0002_0008, 32'hCAFEF00D,  4'hF, 32'h0,        4, 1, 0};
      vecs[10] = '{1'b0, 32'h0002_000A, 32'h0,         4'h0, 32'hCAFEF00D, 1, 0, 0};
      vecs[11] = '{1'b1, 32'h0002_0008, 32'h11223344,  4'h8, 32'h0,        1, 0, 0};
      vecs[12] = '{1'b0, 32'h0002_0008, 32'h0,         4'h0, 32'h11FEF00D, 1, 0, 0};
      vecs[13] = '{1'b0, 32'h0001_5000, 32'h0,         4'h0, 32'h00015000, 4, 1, 0};
      vecs[14] = '{1'b0, 32'h0000_D000, 32'h0,         4'h0, 32'h0000D000, 1, 0, 0};
      vecs[15] = '{1'b0, 32'h0000_9000, 32'h0,         4'h0, 32'h00009000, 4, 1, 0};
      vecs[16] = '{1'b0, 32'h0000_5000, 32'h0,         4'h0, 32'h00005000, 4, 1, 0};
      vecs[17] = '{1'b0, 32'h0001_1000, 32'h0,         4'h0, 32'h00011000, 1, 0, 0};
      vecs[18] = '{1'b0, 32'h0000_4000, 32'h0,         4'h0, 32'h00004000, 4, 1, 0};
      vecs[19] = '{1'b0, 32'h0000_8000, 32'h0,         4'h0, 32'h00008000, 4, 1, 0};
      vecs[20] = '{1'b0, 32'h0000_C000, 32'h0,         4'h0, 32'h0000C000, 4, 1, 0};
      vecs[21] = '{1'b0, 32'h0001_0000, 32'h0,         4'h0, 32'h00010000, 5, 1, 1};

      repeat (3) @(negedge clk);
      check("reset resp_valid", {63'd0, cpu_resp_valid}, 64'd0);
      check("reset rdata", {32'd0, cpu_rdata}, 64'd0);
      check("reset mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
      check("reset mem_req_addr", {32'd0, mem_req_addr}, 64'd0);
      rst = 1'b1;
      @(negedge clk);
      check("cpu_ready after reset", {63'd0, cpu_ready}, 64'd1);

      run_vecs(0, 8);
      check("wb addr way0 victim", {32'd0, wb_addr}, 64'h1000);
      check("wb line word1", {32'd0, wb_line[32 +: 32]}, 64'hAAAA5678);
      check("wb line word0", {32'd0, wb_line[0 +: 32]}, 64'hDEADBEEF);
      check("refill addr after wb", {32'd0, rd_addr}, 64'h0001_1000);

      run_vecs(9, 21);
      check("wb addr dirty store-miss line", {32'd0, wb_addr}, 64'h0002_0000);
      check("wb line word2", {32'd0, wb_line[64 +: 32]}, 64'h11FEF00D);

      // Refill request stalled by mem_req_ready low for 10 cycles.
      rd0 = rd_cnt;
      @(negedge clk);
      mem_req_ready = 1'b0;
      issue(1'b0, 32'h0003_0040, 32'h0, 4'h0);
      @(negedge clk);
      cpu_valid = 1'b0;
      stable = 1'b1; rdy_seen = 1'b0; resp_seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         stable    = stable && mem_req_valid && !mem_req_we && (mem_req_addr == 32'h0003_0040);
         rdy_seen  = rdy_seen || cpu_ready;
         resp_seen = resp_seen || cpu_resp_valid;
      end
      check("stall req stable", {63'd0, stable}, 64'd1);
      check("stall cpu_ready low", {63'd0, rdy_seen}, 64'd0);
      check("stall no response", {63'd0, resp_seen}, 64'd0);
      mem_req_ready = 1'b1;
      wait_resp(rdata, lat);
      check("stall rdata", {32'd0, rdata}, 64'h0003_0040);
      check("stall single refill", 64'(rd_cnt - rd0), 64'd1);

      // Reset while waiting for refill data.
      resp_hold = 1'b1;
      rd0 = rd_cnt;
      issue(1'b0, 32'h0007_0080, 32'h0, 4'h0);
      n = 0;
      do begin
         @(negedge clk);
         cpu_valid = 1'b0;
         n++;
      end while (rd_cnt == rd0 && n < 50);
      check("reset-test refill issued", 64'(rd_cnt - rd0), 64'd1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("midreset cpu_ready", {63'd0, cpu_ready}, 64'd1);
      check("midreset resp_valid", {63'd0, cpu_resp_valid}, 64'd0);
      check("midreset rdata", {32'd0, cpu_rdata}, 64'd0);
      check("midreset mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
      check("midreset mem_req_we", {63'd0, mem_req_we}, 64'd0);
      check("midreset mem_req_addr", {32'd0, mem_req_addr}, 64'd0);
      check("midreset mem_req_wdata zero", {63'd0, |mem_req_wdata}, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      resp_hold = 1'b0;

      rd0 = rd_cnt;
      issue(1'b0, 32'h0000_1000, 32'h0, 4'h0);
      wait_resp(rdata, lat);
      check("post-reset 0x1000 rdata", {32'd0, rdata}, 64'hDEADBEEF);
      check("post-reset 0x1000 miss latency", 64'(lat), 64'd4);
      check("post-reset 0x1000 refill", 64'(rd_cnt - rd0), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
